// File: rtl/uart_tx_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_buffer                                                |
// | Purpose  : byte FIFO that drains into a UART data register, bounded by   |
// |            the WSPACE credit read from the UART control register.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic [AW:0] level,
    output logic        empty,
    output logic        uart_address,
    output logic        uart_read,
    output logic        uart_write,
    output logic [31:0] uart_writedata,
    input  logic [31:0] uart_readdata
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_POLL  = 2'd1;
    localparam logic [1:0]  c_WAIT  = 2'd2;
    localparam logic [1:0]  c_WRITE = 2'd3;
    localparam logic [AW:0] c_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] c_ONE   = (AW + 1)'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [15:0]   r_credit;
    logic [15:0]   w_credit_dec;
    logic [15:0]   w_wspace;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    assign w_wspace     = uart_readdata[31:16];
    assign w_unused     = ^uart_readdata[15:0];
    assign wr_ready     = (r_level != c_FULL);
    assign w_push       = wr_valid && wr_ready;
    assign w_pop        = (r_state == c_WRITE) && (r_level != '0);
    // Credit saturates at zero rather than wrapping.
    assign w_credit_dec = (r_credit != 16'd0) ? (r_credit - 16'd1) : 16'd0;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_ONE;
                2'b01:   r_level <= r_level - c_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_level != '0) begin
                    w_state_nxt = (r_credit != 16'd0) ? c_WRITE : c_POLL;
                end
            end
            c_POLL:  w_state_nxt = c_WAIT;
            c_WAIT:  w_state_nxt = (w_wspace != 16'd0) ? c_WRITE : c_IDLE;
            c_WRITE: begin
                // Continue the burst only if both credit and another byte remain.
                if ((w_credit_dec != 16'd0) && (r_level > c_ONE)) begin
                    w_state_nxt = c_WRITE;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_credit <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_WAIT) begin
                r_credit <= w_wspace;
            end else if (r_state == c_WRITE) begin
                r_credit <= w_credit_dec;
            end
        end
    end

    assign level          = r_level;
    assign empty          = (r_level == '0);
    assign uart_read      = (r_state == c_POLL);
    assign uart_address   = (r_state == c_POLL);
    assign uart_write     = (r_state == c_WRITE);
    assign uart_writedata = (r_state == c_WRITE) ? {24'h0, r_mem[r_rd_ptr]} : 32'h0;

endmodule
`default_nettype wire
